// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared widths, NOP encoding, FSM states and FIFO entry type for the fetch unit
package fetch_unit_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstBus-1:0] NOP_INST = 32'h00000013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HALT = 2'd3
    } fetch_state_e;

    // 65-bit buffer entry: {misalign, pc, inst}
    typedef struct packed {
        logic                   misalign;
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// rtl/fetch_unit_fifo.sv - two-entry instruction buffer (module fetch_fifo) with clear, push, pop and count
module fetch_fifo
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;

    // A push alongside clear lands in slot 0 so the flushed buffer holds exactly that entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clear) begin
            rd_ptr <= 1'b0;
            wr_ptr <= push;
            count  <= {1'b0, push};
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[clear ? 1'b0 : wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with redirect flush; FETCH_MISALIGN_CHK_EN enables misaligned-target halt
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC   = 32'h00000000,
    parameter int                     FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect,
    input  logic [InstAddrBus-1:0] redirect_pc,
    output logic                   imem_req,
    output logic [InstAddrBus-1:0] imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [InstBus-1:0]     imem_rdata,
    output logic                   if_valid,
    output logic [InstAddrBus-1:0] if_pc,
    output logic [InstBus-1:0]     if_inst,
    input  logic                   id_ready,
    output logic                   if_misalign
);

    fetch_state_e           state_q, state_d;
    logic [InstAddrBus-1:0] fetch_pc_q, fetch_pc_d;
    logic [InstAddrBus-1:0] redirect_target;
    logic                   misaligned;
    logic                   grant;
    logic                   fifo_clear, fifo_push, fifo_pop;
    fetch_entry_t           push_entry, head;
    logic [1:0]             fifo_count;

`ifdef FETCH_MISALIGN_CHK_EN
    assign redirect_target = redirect_pc;
    assign misaligned      = redirect_pc[1:0] != 2'b00;
`else
    assign redirect_target = redirect_pc & ~32'h3;
    assign misaligned      = 1'b0;
`endif

    // Only S_REQ has nothing outstanding, so buffer occupancy alone gates the request.
    assign imem_req  = !rst && (state_q == S_REQ) && (int'(fifo_count) < FIFO_DEPTH);
    assign imem_addr = fetch_pc_q;
    assign grant     = imem_req && imem_gnt;

    assign if_valid    = fifo_count != 2'd0;
    assign if_pc       = if_valid ? head.pc : '0;
    assign if_inst     = if_valid ? head.inst : NOP_INST;
    assign if_misalign = if_valid && head.misalign;
    assign fifo_pop    = if_valid && id_ready && !redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        fifo_clear = 1'b0;
        fifo_push  = 1'b0;
        push_entry = '{misalign: 1'b0, pc: fetch_pc_q - 32'd4, inst: imem_rdata};

        if (redirect) begin
            fifo_clear = 1'b1;
            fetch_pc_d = redirect_target;
            // A response already in flight must be swallowed unless it is arriving right now.
            case (state_q)
                S_REQ:          state_d = grant ? S_DROP : S_REQ;
                S_WAIT, S_DROP: state_d = imem_rvalid ? S_REQ : S_DROP;
                default:        state_d = S_REQ;
            endcase
            if (misaligned) begin
                fifo_push  = 1'b1;
                push_entry = '{misalign: 1'b1, pc: redirect_pc, inst: NOP_INST};
                state_d    = S_HALT;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (grant) begin
                        state_d    = S_WAIT;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_d   = S_REQ;
                        fifo_push = 1'b1;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) state_d = S_REQ;
                end
                default: state_d = state_q;
            endcase
        end
    end

    fetch_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear      (fifo_clear),
        .push       (fifo_push),
        .pop        (fifo_pop),
        .push_entry (push_entry),
        .head       (head),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit with a latency-configurable memory model
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_ready;
    logic        if_misalign;

    int n_checks = 0;
    int n_pass   = 0;
    int lat      = 1;

    logic [31:0] req_log[$];
    logic [31:0] pc_log[$];
    logic [31:0] inst_log[$];

    logic        took_q = 1'b0;
    logic [31:0] took_addr_q = '0;
    logic        mem_pend = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    bit          found;

    fetch_unit #(.RESET_PC(32'h00000000), .FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .id_ready    (id_ready),
        .if_misalign (if_misalign)
    );

    always #5 clk = ~clk;

    // Handshake monitor: sees pre-edge values of every accepted request and every consumed instruction.
    always @(posedge clk) begin
        took_q      <= imem_req && imem_gnt;
        took_addr_q <= imem_addr;
        if (!rst) begin
            if (imem_req && imem_gnt) req_log.push_back(imem_addr);
            if (if_valid && id_ready && !redirect) begin
                pc_log.push_back(if_pc);
                inst_log.push_back(if_inst);
            end
        end
    end

    // Memory: answers each grant after 'lat' cycles with data A500_0000 | addr.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (took_q) begin
                mem_pend = 1'b1;
                mem_cnt  = lat;
                mem_addr = took_addr_q;
            end
            if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = 32'hA500_0000 | mem_addr;
                    mem_pend    = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic nxt();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset(input int l);
        rst      = 1'b1;
        redirect = 1'b0;
        id_ready = 1'b1;
        imem_gnt = 1'b1;
        lat      = l;
        repeat (2) nxt();
    endtask

    task automatic release_rst();
        rst = 1'b0;
        req_log.delete();
        pc_log.delete();
        inst_log.delete();
    endtask

    initial begin
        redirect_pc = '0;
        do_reset(1);

        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_inst", if_inst, 32'h00000013);
        check("rst_if_misalign", 32'(if_misalign), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, 32'h0);

        // Streaming with 1-cycle latency: one instruction per two cycles.
        release_rst();
        repeat (7) nxt();
        check("stream_req0", at(req_log, 0), 32'h0);
        check("stream_req1", at(req_log, 1), 32'h4);
        check("stream_req2", at(req_log, 2), 32'h8);
        check("stream_pc0", at(pc_log, 0), 32'h0);
        check("stream_pc1", at(pc_log, 1), 32'h4);
        check("stream_pc2", at(pc_log, 2), 32'h8);
        check("stream_npc", 32'(pc_log.size()), 32'd3);
        check("stream_inst1", at(inst_log, 1), 32'hA500_0004);

        // Backpressure: buffer fills with two entries, then requests stop.
        do_reset(1);
        id_ready = 1'b0;
        release_rst();
        repeat (10) nxt();
        check("bp_req_low", 32'(imem_req), 32'd0);
        check("bp_nreq", 32'(req_log.size()), 32'd2);
        check("bp_if_valid", 32'(if_valid), 32'd1);
        check("bp_if_pc", if_pc, 32'h0);
        id_ready = 1'b1;
        repeat (6) nxt();
        check("bp_pc0", at(pc_log, 0), 32'h0);
        check("bp_pc1", at(pc_log, 1), 32'h4);
        check("bp_pc2", at(pc_log, 2), 32'h8);

        // Redirect while waiting on the response for 0x8.
        do_reset(3);
        release_rst();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            nxt();
            if (at(req_log, 2) == 32'h8) found = 1'b1;
        end
        check("wait_grant8", 32'(found), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        req_log.delete();
        pc_log.delete();
        inst_log.delete();
        nxt();
        redirect = 1'b0;
        check("wait_drop_req", 32'(imem_req), 32'd0);
        check("wait_drop_valid", 32'(if_valid), 32'd0);
        repeat (12) nxt();
        check("wait_req0", at(req_log, 0), 32'h100);
        check("wait_pc0", at(pc_log, 0), 32'h100);
        check("wait_inst0", at(inst_log, 0), 32'hA500_0100);

        // Redirect in the same cycle as a grant; stale response comes back 3 cycles later.
        do_reset(3);
        release_rst();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        nxt();
        redirect = 1'b0;
        check("gnt_drop_req", 32'(imem_req), 32'd0);
        repeat (3) nxt();
        check("gnt_req", 32'(imem_req), 32'd1);
        check("gnt_addr", imem_addr, 32'h40);
        check("gnt_no_stale", 32'(if_valid), 32'd0);
        repeat (8) nxt();
        check("gnt_pc0", at(pc_log, 0), 32'h40);
        check("gnt_inst0", at(inst_log, 0), 32'hA500_0040);

        // Misaligned redirect target.
        do_reset(1);
        imem_gnt = 1'b0;
        release_rst();
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        nxt();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        id_ready = 1'b0;
        check("mis_valid", 32'(if_valid), 32'd1);
        check("mis_flag", 32'(if_misalign), 32'd1);
        check("mis_inst", if_inst, 32'h00000013);
        check("mis_pc", if_pc, 32'h102);
        imem_gnt = 1'b1;
        repeat (5) nxt();
        check("mis_halt_req", 32'(imem_req), 32'd0);
        check("mis_halt_nreq", 32'(req_log.size()), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        nxt();
        redirect = 1'b0;
        check("mis_resume_req", 32'(imem_req), 32'd1);
        check("mis_resume_addr", imem_addr, 32'h200);
        check("mis_resume_valid", 32'(if_valid), 32'd0);
`else
        check("mis_off_req", 32'(imem_req), 32'd1);
        check("mis_off_addr", imem_addr, 32'h100);
        check("mis_off_flag", 32'(if_misalign), 32'd0);
        imem_gnt = 1'b1;
        repeat (6) nxt();
        check("mis_off_pc0", at(pc_log, 0), 32'h100);
`endif

        // Reset while waiting; the response arrives during reset and must be ignored.
        do_reset(2);
        release_rst();
        nxt();
        rst = 1'b1;
        nxt();
        check("rwait_valid", 32'(if_valid), 32'd0);
        check("rwait_inst", if_inst, 32'h00000013);
        check("rwait_req", 32'(imem_req), 32'd0);
        check("rwait_addr", imem_addr, 32'h0);
        nxt();
        check("rwait_stale", 32'(if_valid), 32'd0);
        release_rst();
        repeat (6) nxt();
        check("rwait_req0", at(req_log, 0), 32'h0);
        check("rwait_pc0", at(pc_log, 0), 32'h0);
        check("rwait_npc", 32'(pc_log.size()), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
